// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: default width, ALU control
// codes and the sequencing FSM states.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_GTE = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_LTE = 4'b1001;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic is_defined_ctl(input logic [3:0] ctl);
        return (ctl == ALU_AND) || (ctl == ALU_OR)  || (ctl == ALU_ADD) ||
               (ctl == ALU_SUB) || (ctl == ALU_GTE) || (ctl == ALU_SLL) ||
               (ctl == ALU_LTE);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath. With ALU_SERIAL_SHIFT_EN defined the barrel
// shifter is omitted and SLL passes operand A through (the shamt==0 result).
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [3:0]      alu_ctl,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    logic ge_signed;
    logic le_signed;

    assign ge_signed = ($signed(a) >= $signed(b));
    assign le_signed = ($signed(a) <= $signed(b));

    always_comb begin
        result  = '0;
        illegal = !is_defined_ctl(alu_ctl);
        case (alu_ctl)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
`ifdef ALU_SERIAL_SHIFT_EN
            // Non-zero shift amounts are completed by the stage's serial shifter.
            ALU_SLL: result = a;
`else
            ALU_SLL: result = a << b[4:0];
`endif
            ALU_GTE: result = {{(XLEN-1){1'b0}}, ge_signed};
            ALU_LTE: result = {{(XLEN-1){1'b0}}, le_signed};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: valid/ready handshake, registered result/flags and the
// IDLE/SHIFT sequencer. ALU_SERIAL_SHIFT_EN selects a 1-bit/cycle SLL.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctl,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic            dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready on
    // the same side; valid never depends on ready, and the output payload
    // holds while out_valid && !out_ready.

    state_t          state;
    state_t          next_state;
    logic            accept;
    logic            shift_start;
    logic            shift_done;
    logic [XLEN-1:0] shift_result;
    logic [XLEN-1:0] core_result;
    logic            core_illegal;

    alu_core #(.XLEN(XLEN)) u_core (
        .alu_ctl (alu_ctl),
        .a       (src_a),
        .b       (src_b),
        .result  (core_result),
        .illegal (core_illegal)
    );

    assign accept = in_valid && in_ready;

`ifdef ALU_SERIAL_SHIFT_EN
    logic [XLEN-1:0] shreg;
    logic [4:0]      shcnt;

    assign shift_start  = accept && (alu_ctl == ALU_SLL) && (src_b[4:0] != 5'd0);
    assign shift_done   = (state == SHIFT) && (shcnt == 5'd1);
    assign shift_result = {shreg[XLEN-2:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            shcnt <= '0;
        end else if (shift_start) begin
            shreg <= src_a;
            shcnt <= src_b[4:0];
        end else if (state == SHIFT) begin
            shreg <= shift_result;
            shcnt <= shcnt - 5'd1;
        end
    end
`else
    assign shift_start  = 1'b0;
    assign shift_done   = 1'b0;
    assign shift_result = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (shift_start) next_state = SHIFT;
            SHIFT:   if (shift_done)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && (!out_valid || out_ready);
        dbg_state = (state == SHIFT);
    end

    // A serial SLL is only started when the output slot is empty or being
    // drained, so out_valid is always 0 while in SHIFT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
        end else if (shift_done) begin
            out_valid <= 1'b1;
            result    <= shift_result;
            zero      <= (shift_result == '0);
            illegal   <= 1'b0;
        end else if (accept && !shift_start) begin
            out_valid <= 1'b1;
            result    <= core_result;
            zero      <= (core_result == '0);
            illegal   <= core_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
